csr_access_unit: RTL and testbench
==================================

// Module: csr_access_unit
// PURPOSE
//  Client-side controller for the 5-entry CSR register file: takes CSR/trap requests from EXU,
//  sequences reads/writes over the file's one read port and two write ports, and returns rd data
//  plus a PC redirect for ECALL/MRET. Sits between EXU and the CSR file; owns all CSR update order.
// PARAMETERS
//  XLEN          64     data width of CSRs, src, pc
//  MCAUSE_ECALL  64'd11 value written to mcause on ECALL (environment call from M-mode)
// PORTS
//  clk            in   1     sole clock, rising edge
//  reset          in   1     synchronous, active-high
//  req_valid      in   1     request present; must be held until accepted
//  req_ready      out  1     1 only in IDLE and reset low
//  req_op         in   3     0 CSRRW, 1 CSRRS, 2 CSRRC, 3 ECALL, 4 MRET, 5-7 illegal
//  req_csr        in   12    architectural CSR address (ignored for ECALL/MRET)
//  req_src        in   XLEN  rs1 value or zero-extended zimm
//  req_src_zero   in   1     rs1/zimm field is x0/0: suppresses write for CSRRS/CSRRC
//  req_pc         in   XLEN  PC of the instruction
//  resp_valid     out  1     one-cycle pulse, no backpressure
//  resp_rdata     out  XLEN  old CSR value (CSR ops), 0 for ECALL/MRET/illegal
//  resp_redirect  out  1     with resp_valid: take resp_pc
//  resp_pc        out  XLEN  redirect target
//  resp_illegal   out  1     with resp_valid: bad op or unmapped CSR, no state changed
//  csr_raddr      out  3     CSR file read index (read data combinational, same cycle)
//  csr_rdata      in   XLEN
//  csr_waddr1/csr_wdata1/csr_wen1  out 3/XLEN/1  write port 1, commits at clock edge
//  csr_waddr2/csr_wdata2/csr_wen2  out 3/XLEN/1  write port 2, commits at clock edge
// BEHAVIOUR
//  Index map: mepc 0x341->1, mstatus 0x300->2, mcause 0x342->3, mtvec 0x305->4; index 0 unused.
//  Reset: state IDLE, all registered outputs 0; csr_wen1/2 forced 0 whenever reset=1 (any state).
//  Accept on req_valid&req_ready (cycle 0): latch op/csr/src/src_zero/pc. Unaccepted req ignored.
//  CSR ops: RD (c1) raddr=idx, latch old; WR (c2) resp_valid, resp_rdata=old;
//   new = W:src, S:old|src, C:old&~src; wen1=1 unless (S|C)&src_zero. Back to IDLE.
//  ECALL: E_WR (c1) port1 mepc<=pc, port2 mcause<=MCAUSE_ECALL, both same edge;
//   E_VEC (c2) raddr=4, resp_valid, resp_redirect=1, resp_pc={mtvec[XLEN-1:2],2'b00}.
//  MRET: M_RD (c1) raddr=2, latch mstatus; M_WR (c2) port1 mstatus<=new, raddr=1,
//   resp_valid, resp_redirect=1, resp_pc=mepc. new: MIE[3]<=MPIE[7], MPIE<=1, MPP[12:11]<=2'b11.
//  Illegal (op>=5 or unmapped CSR on ops 0-2): ILL (c1) resp_valid, resp_illegal=1, no wen.
//  Port2 used only in E_WR; port1/port2 never target same index in one cycle.
//  Next request accepted earliest in the cycle after resp_valid (throughput 1 per 3 cycles).
//  Reset mid-sequence: abandon, no further writes; writes already committed stay.
//  resp_* outputs meaningful only while resp_valid=1; otherwise 0.
// STRUCTURE
//  csr_pkg: CSR index constants, 12-bit address constants, op encoding, FSM state enum
//   (IDLE,RD,WR,E_WR,E_VEC,M_RD,M_WR,ILL), mstatus bit positions.
//  One sub-module: csr_addr_decode (12-bit addr -> 3-bit index + hit), combinational.
// TESTING (bench models CSR file: combinational read, writes at edge, mstatus reset 0xa00001800)
//  1 Reset, then CSRRW 0x305 src=0x80000100 -> resp c2 rdata=0, mtvec=0x80000100 after c2 edge.
//  2 CSRRS 0x300 src=0x8, then CSRRC 0x300 src=0x8 -> rdata 0xa00001800 then 0xa00001808; final 0xa00001800.
//  3 CSRRS 0x342 src_zero=1 -> rdata=old mcause, csr_wen1 never asserted.
//  4 ECALL pc=0x80000040, mtvec=0x80000100 -> mepc=0x80000040, mcause=11 same edge; redirect 0x80000100.
//  5 MRET with mstatus=0x1880, mepc=0x80000044 -> mstatus=0x1880->0x1888, redirect 0x80000044.
//  6 CSRRW 0x7C0 and op=6 -> resp_illegal=1, no writes; reset asserted in E_WR -> no wen, req_ready after.

Source files
------------

// File: rtl/csr_pkg.sv
`default_nettype none
// ============================================================================
// Module  : csr_pkg
// Brief   : Shared CSR indices, addresses, op encodings and FSM states.
// Revision: 1.0
// ============================================================================
package csr_pkg;

    localparam logic [2:0] IDX_NONE    = 3'd0;
    localparam logic [2:0] IDX_MEPC    = 3'd1;
    localparam logic [2:0] IDX_MSTATUS = 3'd2;
    localparam logic [2:0] IDX_MCAUSE  = 3'd3;
    localparam logic [2:0] IDX_MTVEC   = 3'd4;

    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;

    localparam logic [2:0] OP_CSRRW = 3'd0;
    localparam logic [2:0] OP_CSRRS = 3'd1;
    localparam logic [2:0] OP_CSRRC = 3'd2;
    localparam logic [2:0] OP_ECALL = 3'd3;
    localparam logic [2:0] OP_MRET  = 3'd4;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        WR    = 3'd2,
        E_WR  = 3'd3,
        E_VEC = 3'd4,
        M_RD  = 3'd5,
        M_WR  = 3'd6,
        ILL   = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/csr_addr_decode.sv
`default_nettype none
// ============================================================================
// Module  : csr_addr_decode
// Brief   : Maps a 12-bit architectural CSR address to a CSR file index.
// Revision: 1.0
// ============================================================================
module csr_addr_decode
    import csr_pkg::*;
(
    input  logic [11:0] addr,
    output logic [2:0]  idx,
    output logic        hit
);

    always_comb begin
        idx = IDX_NONE;
        hit = 1'b0;
        case (addr)
            ADDR_MEPC:    begin idx = IDX_MEPC;    hit = 1'b1; end
            ADDR_MSTATUS: begin idx = IDX_MSTATUS; hit = 1'b1; end
            ADDR_MCAUSE:  begin idx = IDX_MCAUSE;  hit = 1'b1; end
            ADDR_MTVEC:   begin idx = IDX_MTVEC;   hit = 1'b1; end
            default:      begin idx = IDX_NONE;    hit = 1'b0; end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/csr_access_unit.sv
`default_nettype none
// ============================================================================
// Module  : csr_access_unit
// Brief   : Sequences CSR/ECALL/MRET requests onto a 1R/2W CSR file.
// Revision: 1.0
// ============================================================================
module csr_access_unit
    import csr_pkg::*;
#(
    parameter int              XLEN         = 64,
    parameter logic [XLEN-1:0] MCAUSE_ECALL = {{(XLEN-4){1'b0}}, 4'd11}
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [11:0]     req_csr,
    input  logic [XLEN-1:0] req_src,
    input  logic            req_src_zero,
    input  logic [XLEN-1:0] req_pc,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_redirect,
    output logic [XLEN-1:0] resp_pc,
    output logic            resp_illegal,
    output logic [2:0]      csr_raddr,
    input  logic [XLEN-1:0] csr_rdata,
    output logic [2:0]      csr_waddr1,
    output logic [XLEN-1:0] csr_wdata1,
    output logic            csr_wen1,
    output logic [2:0]      csr_waddr2,
    output logic [XLEN-1:0] csr_wdata2,
    output logic            csr_wen2
);

    state_t          r_state;
    state_t          w_next;
    logic [2:0]      r_op;
    logic [2:0]      r_idx;
    logic [XLEN-1:0] r_src;
    logic            r_src_zero;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_old;

    logic [2:0]      w_dec_idx;
    logic            w_dec_hit;
    logic            w_accept;
    logic [XLEN-1:0] w_csr_new;
    logic [XLEN-1:0] w_mret_mstatus;
    logic            w_wen1;
    logic            w_wen2;

    csr_addr_decode u_decode (
        .addr (req_csr),
        .idx  (w_dec_idx),
        .hit  (w_dec_hit)
    );

    assign req_ready = (r_state == IDLE) && !reset;
    assign w_accept  = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_op       <= 3'd0;
            r_idx      <= IDX_NONE;
            r_src      <= '0;
            r_src_zero <= 1'b0;
            r_pc       <= '0;
            r_old      <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op       <= req_op;
                r_idx      <= w_dec_idx;
                r_src      <= req_src;
                r_src_zero <= req_src_zero;
                r_pc       <= req_pc;
            end
            if (r_state == RD || r_state == M_RD) begin
                r_old <= csr_rdata;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    case (req_op)
                        OP_CSRRW, OP_CSRRS, OP_CSRRC: w_next = w_dec_hit ? RD : ILL;
                        OP_ECALL:                     w_next = E_WR;
                        OP_MRET:                      w_next = M_RD;
                        default:                      w_next = ILL;
                    endcase
                end
            end
            RD:      w_next = WR;
            E_WR:    w_next = E_VEC;
            M_RD:    w_next = M_WR;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_csr_new = r_src;
        case (r_op)
            OP_CSRRS: w_csr_new = r_old | r_src;
            OP_CSRRC: w_csr_new = r_old & ~r_src;
            default:  w_csr_new = r_src;
        endcase
    end

    always_comb begin
        w_mret_mstatus                                = r_old;
        w_mret_mstatus[MSTATUS_MIE]                   = r_old[MSTATUS_MPIE];
        w_mret_mstatus[MSTATUS_MPIE]                  = 1'b1;
        w_mret_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

    always_comb begin
        csr_raddr     = IDX_NONE;
        csr_waddr1    = IDX_NONE;
        csr_wdata1    = '0;
        w_wen1        = 1'b0;
        csr_waddr2    = IDX_NONE;
        csr_wdata2    = '0;
        w_wen2        = 1'b0;
        resp_valid    = 1'b0;
        resp_rdata    = '0;
        resp_redirect = 1'b0;
        resp_pc       = '0;
        resp_illegal  = 1'b0;
        case (r_state)
            RD: csr_raddr = r_idx;
            WR: begin
                resp_valid = 1'b1;
                resp_rdata = r_old;
                csr_waddr1 = r_idx;
                csr_wdata1 = w_csr_new;
                // Set/clear with an x0/zero source must not write (side-effect free read).
                w_wen1     = !(((r_op == OP_CSRRS) || (r_op == OP_CSRRC)) && r_src_zero);
            end
            E_WR: begin
                csr_waddr1 = IDX_MEPC;
                csr_wdata1 = r_pc;
                w_wen1     = 1'b1;
                csr_waddr2 = IDX_MCAUSE;
                csr_wdata2 = MCAUSE_ECALL;
                w_wen2     = 1'b1;
            end
            E_VEC: begin
                csr_raddr     = IDX_MTVEC;
                resp_valid    = 1'b1;
                resp_redirect = 1'b1;
                resp_pc       = {csr_rdata[XLEN-1:2], 2'b00};
            end
            M_RD: csr_raddr = IDX_MSTATUS;
            M_WR: begin
                csr_waddr1    = IDX_MSTATUS;
                csr_wdata1    = w_mret_mstatus;
                w_wen1        = 1'b1;
                csr_raddr     = IDX_MEPC;
                resp_valid    = 1'b1;
                resp_redirect = 1'b1;
                resp_pc       = csr_rdata;
            end
            ILL: begin
                resp_valid   = 1'b1;
                resp_illegal = 1'b1;
            end
            default: ;
        endcase
    end

    // Write enables are squashed combinationally so a reset in any state blocks the commit.
    assign csr_wen1 = w_wen1 && !reset;
    assign csr_wen2 = w_wen2 && !reset;

endmodule
`default_nettype wire

// File: tb/tb_csr_access_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_csr_access_unit
// Brief   : Directed self-checking bench with a behavioural CSR file model.
// Revision: 1.0
// ============================================================================
module tb_csr_access_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [11:0] req_csr;
    logic [63:0] req_src;
    logic        req_src_zero;
    logic [63:0] req_pc;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_redirect;
    logic [63:0] resp_pc;
    logic        resp_illegal;
    logic [2:0]  csr_raddr;
    logic [63:0] csr_rdata;
    logic [2:0]  csr_waddr1;
    logic [63:0] csr_wdata1;
    logic        csr_wen1;
    logic [2:0]  csr_waddr2;
    logic [63:0] csr_wdata2;
    logic        csr_wen2;

    logic [63:0] mem [0:7];
    logic        model_init;
    int          wen1_cnt;
    int          wen2_cnt;
    int          both_cnt;

    int          checks;
    int          errors;

    logic [63:0] rsp_rdata;
    logic        rsp_redirect;
    logic [63:0] rsp_pc;
    logic        rsp_illegal;
    int          rsp_lat;

    csr_access_unit dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_csr       (req_csr),
        .req_src       (req_src),
        .req_src_zero  (req_src_zero),
        .req_pc        (req_pc),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_redirect (resp_redirect),
        .resp_pc       (resp_pc),
        .resp_illegal  (resp_illegal),
        .csr_raddr     (csr_raddr),
        .csr_rdata     (csr_rdata),
        .csr_waddr1    (csr_waddr1),
        .csr_wdata1    (csr_wdata1),
        .csr_wen1      (csr_wen1),
        .csr_waddr2    (csr_waddr2),
        .csr_wdata2    (csr_wdata2),
        .csr_wen2      (csr_wen2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign csr_rdata = mem[csr_raddr];

    always @(posedge clk) begin
        if (model_init) begin
            for (int i = 0; i < 8; i++) mem[i] <= 64'd0;
            mem[2]   <= 64'ha00001800;
            wen1_cnt <= 0;
            wen2_cnt <= 0;
            both_cnt <= 0;
        end else begin
            if (csr_wen1) begin
                mem[csr_waddr1] <= csr_wdata1;
                wen1_cnt        <= wen1_cnt + 1;
            end
            if (csr_wen2) begin
                mem[csr_waddr2] <= csr_wdata2;
                wen2_cnt        <= wen2_cnt + 1;
            end
            if (csr_wen1 && csr_wen2) both_cnt <= both_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issues one request and captures the response; ends one negedge after the response cycle.
    task automatic do_req(input logic [2:0] op, input logic [11:0] csr, input logic [63:0] src,
                          input logic sz, input logic [63:0] pc);
        int n;
        @(negedge clk);
        req_valid    = 1'b1;
        req_op       = op;
        req_csr      = csr;
        req_src      = src;
        req_src_zero = sz;
        req_pc       = pc;
        n = 0;
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_req", {63'd0, req_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid    = 1'b0;
        req_op       = 3'd0;
        req_csr      = 12'd0;
        req_src      = 64'd0;
        req_src_zero = 1'b0;
        req_pc       = 64'd0;
        rsp_lat      = 0;
        for (int c = 1; c <= 10; c++) begin
            if (resp_valid) begin
                rsp_lat      = c;
                rsp_rdata    = resp_rdata;
                rsp_redirect = resp_redirect;
                rsp_pc       = resp_pc;
                rsp_illegal  = resp_illegal;
                break;
            end
            @(negedge clk);
        end
        if (rsp_lat == 0) check("resp_timeout", 64'd0, 64'd1);
        @(negedge clk);
    endtask

    initial begin
        int w1;
        int w2;
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        model_init   = 1'b1;
        req_valid    = 1'b0;
        req_op       = 3'd0;
        req_csr      = 12'd0;
        req_src      = 64'd0;
        req_src_zero = 1'b0;
        req_pc       = 64'd0;
        repeat (3) @(negedge clk);
        check("rst_ready",      {63'd0, req_ready},  64'd0);
        check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst_wen1",       {63'd0, csr_wen1},   64'd0);
        model_init = 1'b0;
        reset      = 1'b0;
        #1;
        check("post_rst_ready", {63'd0, req_ready}, 64'd1);

        // CSRRW mtvec
        do_req(3'd0, 12'h305, 64'h80000100, 1'b0, 64'd0);
        check("rw_lat",   rsp_lat,   64'd2);
        check("rw_rdata", rsp_rdata, 64'd0);
        check("rw_illegal", {63'd0, rsp_illegal}, 64'd0);
        check("rw_mtvec", mem[4],    64'h80000100);

        // CSRRS / CSRRC mstatus
        do_req(3'd1, 12'h300, 64'h8, 1'b0, 64'd0);
        check("rs_rdata", rsp_rdata, 64'ha00001800);
        check("rs_mstatus", mem[2],  64'ha00001808);
        do_req(3'd2, 12'h300, 64'h8, 1'b0, 64'd0);
        check("rc_rdata", rsp_rdata, 64'ha00001808);
        check("rc_mstatus", mem[2],  64'ha00001800);

        // ECALL
        w2 = wen2_cnt;
        do_req(3'd3, 12'h000, 64'd0, 1'b0, 64'h80000040);
        check("ec_lat",      rsp_lat, 64'd2);
        check("ec_redirect", {63'd0, rsp_redirect}, 64'd1);
        check("ec_pc",       rsp_pc,    64'h80000100);
        check("ec_rdata",    rsp_rdata, 64'd0);
        check("ec_mepc",     mem[1],    64'h80000040);
        check("ec_mcause",   mem[3],    64'd11);
        check("ec_same_edge", both_cnt, 64'd1);
        check("ec_wen2_cnt", wen2_cnt - w2, 64'd1);

        // CSRRS with zero source: read only
        w1 = wen1_cnt;
        do_req(3'd1, 12'h342, 64'h0, 1'b1, 64'd0);
        check("rsz_rdata", rsp_rdata, 64'd11);
        check("rsz_nowen", wen1_cnt - w1, 64'd0);

        // MRET
        do_req(3'd0, 12'h300, 64'h1880, 1'b0, 64'd0);
        do_req(3'd0, 12'h341, 64'h80000044, 1'b0, 64'd0);
        do_req(3'd4, 12'h000, 64'd0, 1'b0, 64'd0);
        check("mret_lat",      rsp_lat, 64'd2);
        check("mret_redirect", {63'd0, rsp_redirect}, 64'd1);
        check("mret_pc",       rsp_pc,  64'h80000044);
        check("mret_mstatus",  mem[2],  64'h1888);

        // Illegal: unmapped CSR and bad op
        w1 = wen1_cnt;
        w2 = wen2_cnt;
        do_req(3'd0, 12'h7C0, 64'hdead, 1'b0, 64'd0);
        check("ill_csr_lat",  rsp_lat, 64'd1);
        check("ill_csr_flag", {63'd0, rsp_illegal}, 64'd1);
        check("ill_csr_rdata", rsp_rdata, 64'd0);
        do_req(3'd6, 12'h300, 64'hdead, 1'b0, 64'd0);
        check("ill_op_flag",  {63'd0, rsp_illegal}, 64'd1);
        check("ill_op_redirect", {63'd0, rsp_redirect}, 64'd0);
        check("ill_nowen", (wen1_cnt - w1) + (wen2_cnt - w2), 64'd0);
        check("ill_mstatus", mem[2], 64'h1888);

        // Reset while in E_WR
        w1 = wen1_cnt;
        w2 = wen2_cnt;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 3'd3;
        req_pc    = 64'h1234;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_pc    = 64'd0;
        reset     = 1'b1;
        #1;
        check("rst_ewr_wen1", {63'd0, csr_wen1}, 64'd0);
        check("rst_ewr_wen2", {63'd0, csr_wen2}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_ewr_ready", {63'd0, req_ready},  64'd1);
        check("rst_ewr_resp",  {63'd0, resp_valid}, 64'd0);
        @(negedge clk);
        check("rst_ewr_mepc",  mem[1], 64'h80000044);
        check("rst_ewr_nowen", (wen1_cnt - w1) + (wen2_cnt - w2), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
